// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit indices and writeback sequencer states.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_RSB = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SBC = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_ORR = 4'b0110;
  localparam logic [3:0] OP_EOR = 4'b0111;
  localparam logic [3:0] OP_STR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM_REQ, ST_MEM_DONE} wb_state_e;

  function automatic logic is_alu_write(input logic [3:0] op);
    return ~op[3];
  endfunction

  // Every opcode outside the named classes is a store.
  function automatic logic is_str(input logic [3:0] op);
    return op[3] && op != OP_CMP && op != OP_LDR && op != OP_NOP;
  endfunction

  function automatic logic sets_flags(input logic [3:0] op, input logic s);
    return (s && op <= OP_AND) || op == OP_CMP;
  endfunction

endpackage

// File: rtl/alu_writeback_mem_fsm.sv
// Single-outstanding load/store sequencer: IDLE -> MEM_REQ -> (MEM_DONE for loads) -> IDLE.
module wb_mem_fsm
  import alu_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_we,
  input  logic [DW-1:0]     start_addr,
  input  logic [DW-1:0]     start_wdata,
  input  logic [REG_AW-1:0] start_rd,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic              in_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              ld_we,
  output logic [REG_AW-1:0] ld_addr,
  output logic [DW-1:0]     ld_data
);

  wb_state_e         state;
  logic [REG_AW-1:0] ld_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ld_rd     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_MEM_REQ;
          in_ready  <= 1'b0;
          mem_req   <= 1'b1;
          mem_we    <= start_we;
          mem_addr  <= start_addr;
          mem_wdata <= start_wdata;
          ld_rd     <= start_rd;
        end
        ST_MEM_REQ: if (mem_ack) begin
          mem_req  <= 1'b0;
          state    <= mem_we ? ST_IDLE : ST_MEM_DONE;
          in_ready <= mem_we;
        end
        ST_MEM_DONE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

  // Load data is taken straight off the ack beat; the top registers it into Rf_W*.
  assign ld_we   = (state == ST_MEM_REQ) && mem_ack && !mem_we;
  assign ld_addr = ld_rd;
  assign ld_data = mem_rdata;

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: result capture, NZCV register, RF write mux, memory sequencing.
// Define ALU_WB_FWD_EN to expose the Fwd_* same-cycle bypass outputs.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DW     = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [3:0]        Opcode,
  input  logic              S,
  input  logic              Condition_met,
  input  logic [DW-1:0]     Result,
  input  logic [3:0]        Flags_In,
  input  logic [REG_AW-1:0] Rd,
  input  logic [DW-1:0]     Store_Data,
  output logic              Rf_We,
  output logic [REG_AW-1:0] Rf_Waddr,
  output logic [DW-1:0]     Rf_Wdata,
  output logic [3:0]        Flags,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [DW-1:0]     Mem_Addr,
  output logic [DW-1:0]     Mem_Wdata,
  input  logic              Mem_Ack,
  input  logic [DW-1:0]     Mem_Rdata
`ifdef ALU_WB_FWD_EN
  ,
  output logic              Fwd_Valid,
  output logic [REG_AW-1:0] Fwd_Addr,
  output logic [DW-1:0]     Fwd_Data
`endif
);

  logic              live;
  logic              alu_wr;
  logic              flag_upd;
  logic              mem_start;
  logic              ld_we;
  logic [REG_AW-1:0] ld_addr;
  logic [DW-1:0]     ld_data;

  // Condition-failed and NOP instructions retire silently.
  assign live      = In_Valid && In_Ready && Condition_met && Opcode != OP_NOP;
  assign alu_wr    = live && is_alu_write(Opcode);
  assign flag_upd  = live && sets_flags(Opcode, S);
  assign mem_start = live && (Opcode == OP_LDR || is_str(Opcode));

  wb_mem_fsm #(.REG_AW(REG_AW), .DW(DW)) u_mem_fsm (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .start      (mem_start),
    .start_we   (is_str(Opcode)),
    .start_addr (Result),
    .start_wdata(Store_Data),
    .start_rd   (Rd),
    .mem_ack    (Mem_Ack),
    .mem_rdata  (Mem_Rdata),
    .in_ready   (In_Ready),
    .mem_req    (Mem_Req),
    .mem_we     (Mem_We),
    .mem_addr   (Mem_Addr),
    .mem_wdata  (Mem_Wdata),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  // ALU writes and load write-back never coincide: In_Ready is low while a load is in flight.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Rf_We    <= 1'b0;
      Rf_Waddr <= '0;
      Rf_Wdata <= '0;
      Flags    <= 4'b0000;
    end else begin
      Rf_We <= alu_wr || ld_we;
      if (alu_wr) begin
        Rf_Waddr <= Rd;
        Rf_Wdata <= Result;
      end else if (ld_we) begin
        Rf_Waddr <= ld_addr;
        Rf_Wdata <= ld_data;
      end
      if (flag_upd) Flags <= Flags_In;
    end
  end

`ifdef ALU_WB_FWD_EN
  assign Fwd_Valid = Rf_We && Reset_n;
  assign Fwd_Addr  = Rf_Waddr;
  assign Fwd_Data  = Rf_Wdata;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: ALU vector table plus load/store/reset sequences.
module tb_alu_writeback;

  localparam int REG_AW = 4;
  localparam int DW     = 32;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              In_Valid;
  logic              In_Ready;
  logic [3:0]        Opcode;
  logic              S;
  logic              Condition_met;
  logic [DW-1:0]     Result;
  logic [3:0]        Flags_In;
  logic [REG_AW-1:0] Rd;
  logic [DW-1:0]     Store_Data;
  logic              Rf_We;
  logic [REG_AW-1:0] Rf_Waddr;
  logic [DW-1:0]     Rf_Wdata;
  logic [3:0]        Flags;
  logic              Mem_Req;
  logic              Mem_We;
  logic [DW-1:0]     Mem_Addr;
  logic [DW-1:0]     Mem_Wdata;
  logic              Mem_Ack;
  logic [DW-1:0]     Mem_Rdata;

  int checks = 0;
  int errors = 0;

  alu_writeback #(.REG_AW(REG_AW), .DW(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Opcode(Opcode), .S(S), .Condition_met(Condition_met), .Result(Result),
    .Flags_In(Flags_In), .Rd(Rd), .Store_Data(Store_Data),
    .Rf_We(Rf_We), .Rf_Waddr(Rf_Waddr), .Rf_Wdata(Rf_Wdata), .Flags(Flags),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic        cond;
    logic [31:0] res;
    logic [3:0]  fl_in;
    logic [3:0]  rd;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic cond,
                       input logic [31:0] res, input logic [3:0] fl, input logic [3:0] rd,
                       input logic [31:0] sd);
    In_Valid = 1'b1; Opcode = op; S = s; Condition_met = cond;
    Result = res; Flags_In = fl; Rd = rd; Store_Data = sd;
  endtask

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  initial begin
    vecs[0] = '{4'h0, 1, 1, 32'h5,        4'b0000, 4'd3,  1, 4'd3,  32'h5,        4'b0000};
    vecs[1] = '{4'h1, 0, 1, 32'h10,       4'b0100, 4'd4,  1, 4'd4,  32'h10,       4'b0000};
    vecs[2] = '{4'hB, 0, 1, 32'h0,        4'b0100, 4'd6,  0, 4'd0,  32'h0,        4'b0100};
    vecs[3] = '{4'hB, 0, 0, 32'h0,        4'b1001, 4'd6,  0, 4'd0,  32'h0,        4'b0100};
    vecs[4] = '{4'h0, 1, 0, 32'h7,        4'b1000, 4'd1,  0, 4'd0,  32'h0,        4'b0100};
    vecs[5] = '{4'h5, 1, 1, 32'hFF,       4'b0010, 4'd15, 1, 4'd15, 32'hFF,       4'b0010};
    vecs[6] = '{4'h6, 1, 1, 32'hA5A5A5A5, 4'b1111, 4'd2,  1, 4'd2,  32'hA5A5A5A5, 4'b0010};
    vecs[7] = '{4'h7, 1, 1, 32'hFFFFFFFF, 4'b1000, 4'd0,  1, 4'd0,  32'hFFFFFFFF, 4'b0010};
    vecs[8] = '{4'hF, 1, 1, 32'h1234,     4'b1111, 4'd8,  0, 4'd0,  32'h0,        4'b0010};
    vecs[9] = '{4'h4, 1, 1, 32'h0,        4'b1001, 4'd9,  1, 4'd9,  32'h0,        4'b1001};

    Reset_n = 1'b0; In_Valid = 1'b0; Opcode = 4'h0; S = 1'b0; Condition_met = 1'b0;
    Result = '0; Flags_In = '0; Rd = '0; Store_Data = '0; Mem_Ack = 1'b0; Mem_Rdata = '0;

    // Reset for two cycles
    tick(); tick();
    check("rst_rf_we", Rf_We, 0);
    check("rst_rf_waddr", Rf_Waddr, 0);
    check("rst_rf_wdata", Rf_Wdata, 0);
    check("rst_flags", Flags, 0);
    check("rst_mem_req", Mem_Req, 0);
    check("rst_mem_we", Mem_We, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_mem_wdata", Mem_Wdata, 0);
    @(negedge Clk); Reset_n = 1'b1;
    tick();
    check("rst_in_ready", In_Ready, 1);

    // Stray ack in IDLE is ignored
    @(negedge Clk); Mem_Ack = 1'b1; Mem_Rdata = 32'hBAD0BAD0;
    tick();
    check("idle_ack_req", Mem_Req, 0);
    check("idle_ack_we", Rf_We, 0);
    @(negedge Clk); Mem_Ack = 1'b0; Mem_Rdata = '0;

    // Back-to-back ALU vectors, one per cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      drive(vecs[i].op, vecs[i].s, vecs[i].cond, vecs[i].res, vecs[i].fl_in, vecs[i].rd, 32'h0);
      tick();
      check($sformatf("vec%0d_rf_we", i), Rf_We, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_waddr", i), Rf_Waddr, vecs[i].exp_addr);
        check($sformatf("vec%0d_wdata", i), Rf_Wdata, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_flags", i), Flags, vecs[i].exp_flags);
      check($sformatf("vec%0d_in_ready", i), In_Ready, 1);
      check($sformatf("vec%0d_mem_req", i), Mem_Req, 0);
    end
    @(negedge Clk); In_Valid = 1'b0;
    tick();
    check("alu_we_one_cycle", Rf_We, 0);

    // LDR with condition failed: no memory activity
    @(negedge Clk); drive(4'hD, 0, 0, 32'h300, 4'b0, 4'd5, 32'h0);
    tick();
    check("ldr_nc_req", Mem_Req, 0);
    check("ldr_nc_ready", In_Ready, 1);
    @(negedge Clk); In_Valid = 1'b0;

    // LDR, ack after three Mem_Req cycles
    @(negedge Clk); drive(4'hD, 0, 1, 32'h100, 4'b0, 4'd7, 32'h0);
    tick();
    check("ldr_req1", Mem_Req, 1);
    check("ldr_we", Mem_We, 0);
    check("ldr_addr", Mem_Addr, 32'h100);
    check("ldr_ready1", In_Ready, 0);
    check("ldr_no_rfwe1", Rf_We, 0);
    @(negedge Clk); In_Valid = 1'b0;
    tick();
    check("ldr_req2", Mem_Req, 1);
    check("ldr_ready2", In_Ready, 0);
    tick();
    check("ldr_req3", Mem_Req, 1);
    check("ldr_addr3", Mem_Addr, 32'h100);
    @(negedge Clk); Mem_Ack = 1'b1; Mem_Rdata = 32'hDEADBEEF;
    tick();
    check("ldr_req_drop", Mem_Req, 0);
    check("ldr_rf_we", Rf_We, 1);
    check("ldr_waddr", Rf_Waddr, 7);
    check("ldr_wdata", Rf_Wdata, 32'hDEADBEEF);
    check("ldr_done_ready", In_Ready, 0);
    @(negedge Clk); Mem_Ack = 1'b0; Mem_Rdata = '0;
    tick();
    check("ldr_we_end", Rf_We, 0);
    check("ldr_idle_ready", In_Ready, 1);
    check("ldr_flags", Flags, 4'b1001);

    // STR acked in the same cycle Mem_Req rises
    @(negedge Clk); drive(4'h8, 1, 1, 32'h200, 4'b1111, 4'd3, 32'h12345678);
    tick();
    check("str_req", Mem_Req, 1);
    check("str_we", Mem_We, 1);
    check("str_addr", Mem_Addr, 32'h200);
    check("str_wdata", Mem_Wdata, 32'h12345678);
    check("str_ready0", In_Ready, 0);
    @(negedge Clk); In_Valid = 1'b0; Mem_Ack = 1'b1;
    tick();
    check("str_req_drop", Mem_Req, 0);
    check("str_no_rfwe", Rf_We, 0);
    check("str_ready1", In_Ready, 1);
    check("str_flags", Flags, 4'b1001);
    @(negedge Clk); Mem_Ack = 1'b0;

    // Reset during MEM_REQ discards the pending load
    @(negedge Clk); drive(4'hD, 0, 1, 32'h400, 4'b0, 4'd11, 32'h0);
    tick();
    check("rmid_req", Mem_Req, 1);
    @(negedge Clk); In_Valid = 1'b0; Reset_n = 1'b0;
    tick();
    check("rmid_req_drop", Mem_Req, 0);
    check("rmid_flags", Flags, 0);
    check("rmid_ready", In_Ready, 1);
    check("rmid_rfwe", Rf_We, 0);
    @(negedge Clk); Reset_n = 1'b1; Mem_Ack = 1'b1; Mem_Rdata = 32'hCAFEF00D;
    tick();
    check("rmid_late_ack", Rf_We, 0);
    check("rmid_late_req", Mem_Req, 0);
    @(negedge Clk); Mem_Ack = 1'b0;
    tick();
    check("rmid_no_write", Rf_We, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
